// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial add/subtract unit.
//   state_e   : FSM state encoding (idle / run / done)
//   WIDTH_MAX : largest supported operand width
package adder_pkg;

  localparam int unsigned WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell, reused every cycle by the serial adder.
//   A, B : operand bits
//   Cin  : carry in
//   Y    : sum bit
//   Cout : carry out
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Y,
  output logic Cout
);

  logic p;

  assign p    = A ^ B;
  assign Y    = p ^ Cin;
  assign Cout = (A & B) | (Cin & p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract unit. One full-adder cell processes one bit per clock,
// LSB first, with a carry flop between bits. A request is taken with start while
// idle; results appear WIDTH cycles later together with a one-cycle done pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, sampled only while idle
//   sub        : 0 = a+b, 1 = a-b (sampled with start)
//   a, b       : operands (sampled with start)
//   busy       : high from the cycle after acceptance through the done cycle
//   done       : one-cycle pulse when sum/cout/ovf update
//   sum        : result, held until the next done
//   cout       : carry out of MSB (not-borrow in subtract mode)
//   ovf        : signed overflow
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  import adder_pkg::*;

  if (WIDTH == 0 || WIDTH > WIDTH_MAX) begin : gen_width_check
    $error("serial_adder: WIDTH must be in 1..%0d", WIDTH_MAX);
  end

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic             fa_y;
  logic             fa_cout;
  logic [WIDTH-1:0] res_shift;

  full_adder u_fa (
    .A    (a_q[0]),
    .B    (b_q[0]),
    .Cin  (carry_q),
    .Y    (fa_y),
    .Cout (fa_cout)
  );

  // Result register fills from the MSB end so the LSB lands at bit 0 after WIDTH shifts.
  always_comb begin
    res_shift            = res_q >> 1;
    res_shift[WIDTH-1]   = fa_y;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          a_d     = a;
          // Subtraction as a + ~b + 1: the +1 enters through the initial carry.
          b_d     = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
        end
      end
      StRun: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = res_shift;
        carry_d = fa_cout;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = StDone;
          sum_d   = res_shift;
          cout_d  = fa_cout;
          // carry_q here is the carry into the MSB.
          ovf_d   = carry_q ^ fa_cout;
          done_d  = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
